board_feeder: RTL and testbench
===============================

Name: board_feeder

Overview:
- Initiator side of the board-evaluation interface; drives the same board / board_valid / white_to_move signals that board_attack consumes.
- Software or search logic writes squares one at a time into an internal 64-square board register; a final write launches an evaluation.
- The block captures attack bitmaps and check flags when board_attack reports done, and returns them over a valid/ready result channel.

Parameters:
- PIECE_WIDTH, 4, bits per square code; MSB is the side bit (1 = black), code 0 = empty square.
- SIDE_WIDTH, 3, piece-type bits below the side bit; must equal PIECE_WIDTH-1.
- BOARD_WIDTH, 256, must equal 64*PIECE_WIDTH; square n occupies bits [n*PIECE_WIDTH +: PIECE_WIDTH], a1=0, h8=63.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low (low = in reset).
- wr_valid  input  1  square write request.
- wr_ready  output  1  write accepted when wr_valid && wr_ready.
- wr_square  input  6  target square index.
- wr_piece  input  PIECE_WIDTH  code written to the square.
- wr_last  input  1  qualifies the accepted write as final; triggers launch.
- wr_white_to_move  input  1  side to move; sampled with the accepted wr_last write.
- clear_board  input  1  zero all squares; honoured only in IDLE.
- board  output  BOARD_WIDTH  board register, driven continuously.
- board_valid  output  1  one-cycle launch pulse.
- white_to_move  output  1  latched side to move.
- is_attacking_done  input  1  completion pulse from board_attack.
- white_is_attacking  input  64  attack bitmap for white.
- black_is_attacking  input  64  attack bitmap for black.
- white_in_check  input  1  check flag for white.
- black_in_check  input  1  check flag for black.
- res_valid  output  1  result available.
- res_ready  input  1  result consumer ready.
- res_white_attacking  output  64  captured white attack bitmap.
- res_black_attacking  output  64  captured black attack bitmap.
- res_white_in_check  output  1  captured white check flag.
- res_black_in_check  output  1  captured black check flag.
- res_illegal  output  1  side that just moved left its own king in check.
- res_timeout  output  1  watchdog expired.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, low): state IDLE; board=0; white_to_move=0; board_valid=0; all res_* outputs=0; busy=0; wr_ready=1 once reset deasserts. Reset asserted mid-operation abandons the evaluation; any late is_attacking_done is then ignored because the state is IDLE.
- FSM states: IDLE, LAUNCH, WAIT, RESULT.
- IDLE, wr_ready=1:
  - An accepted write updates the square on the next edge.
  - clear_board zeroes the whole board. If clear_board and a write occur in the same cycle, the clear is applied first and the write then lands, so the written square holds wr_piece and all others are 0.
  - An accepted write with wr_last=1 latches wr_white_to_move and moves to LAUNCH.
  - Board contents persist between evaluations, so a new position can be an incremental edit.
- LAUNCH: board_valid=1 for exactly this cycle; board is stable. Next state is WAIT. is_attacking_done seen in LAUNCH is ignored (board_attack latency is at least 1 cycle).
- WAIT: on is_attacking_done=1, capture both bitmaps and both check flags and move to RESULT. Done is sampled only in WAIT; it may be a pulse or a level.
- RESULT:
  - res_valid=1; res_* outputs are held stable until res_valid && res_ready, then the state returns to IDLE.
  - res_ready is allowed high before res_valid, giving a one-cycle RESULT.
  - res_illegal = white_to_move ? black_in_check : white_in_check, computed from the captured flags and registered with them.
- wr_ready=0 outside IDLE. wr_valid/clear_board outside IDLE are ignored, not queued.
- Minimum turnaround from last write to res_valid is 3 edges (LAUNCH, WAIT, RESULT) when done returns on the first WAIT cycle.

Optional Feature:
- Macro FEEDER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without done, the block enters RESULT with res_timeout=1, bitmaps=0, flags=0, res_illegal=0.
  - If done arrives in the expiry cycle, done wins and res_timeout=0.
- Undefined: no counter; res_timeout tied 0; WAIT lasts until done arrives.

Decomposition:
- Shared vchess package holds: EMPTY_POSN=0 and the piece/side code constants; the feeder state enum (IDLE, LAUNCH, WAIT, RESULT); a square index helper constant SQUARES=64.
- No sub-module is warranted. The watchdog is a few lines under the macro and lives inline.

Test Plan:
- Reset behaviour: write a1=white king (4'h1), e8=black king (4'h9) with wr_last, white to move; done after 5 cycles with black_in_check=1 -> board_valid pulses once, res_valid, res_illegal=1, res_black_in_check=1.
- Result backpressure: same launch, hold res_ready=0 for 10 cycles while inputs change -> res_* stay stable, wr_ready=0; assert res_ready -> IDLE next cycle.
- Clear semantics: clear_board with a simultaneous write of d4=4'h3 -> board has only square 27 nonzero. clear_board during WAIT -> ignored.
- Reset mid-operation: reset low during WAIT, then done pulses after release -> outputs at reset values, no res_valid.
- Early done ignored: done asserted in LAUNCH only -> block remains in WAIT.
- Watchdog, with FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=8: no done -> res_valid with res_timeout=1 after 8 WAIT cycles. Done on the 8th WAIT cycle -> res_timeout=0.

Source files
------------

// File: rtl/vchess_pkg.sv
// Shared chess constants: square-code fields, the square count and the board_feeder state enum.
package vchess_pkg;

  localparam int unsigned SQUARES    = 64;
  localparam logic [3:0]  EMPTY_POSN = 4'h0;

  // Square code: {side, piece}; side 1 = black.
  localparam logic       SIDE_WHITE   = 1'b0;
  localparam logic       SIDE_BLACK   = 1'b1;
  localparam logic [2:0] PIECE_KING   = 3'd1;
  localparam logic [2:0] PIECE_QUEEN  = 3'd2;
  localparam logic [2:0] PIECE_ROOK   = 3'd3;
  localparam logic [2:0] PIECE_BISHOP = 3'd4;
  localparam logic [2:0] PIECE_KNIGHT = 3'd5;
  localparam logic [2:0] PIECE_PAWN   = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResult
  } feeder_state_e;

endpackage

// File: rtl/board_feeder.sv
// Initiator for board_attack: builds a board square by square, launches an evaluation and
// returns the captured attack result on a valid/ready channel. Watchdog: FEEDER_TIMEOUT_EN.
module board_feeder
  import vchess_pkg::*;
#(
  parameter int unsigned PIECE_WIDTH    = 4,
  parameter int unsigned SIDE_WIDTH     = 3,
  parameter int unsigned BOARD_WIDTH    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [5:0]             wr_square,
  input  logic [PIECE_WIDTH-1:0] wr_piece,
  input  logic                   wr_last,
  input  logic                   wr_white_to_move,
  input  logic                   clear_board,
  output logic [BOARD_WIDTH-1:0] board,
  output logic                   board_valid,
  output logic                   white_to_move,
  input  logic                   is_attacking_done,
  input  logic [63:0]            white_is_attacking,
  input  logic [63:0]            black_is_attacking,
  input  logic                   white_in_check,
  input  logic                   black_in_check,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [63:0]            res_white_attacking,
  output logic [63:0]            res_black_attacking,
  output logic                   res_white_in_check,
  output logic                   res_black_in_check,
  output logic                   res_illegal,
  output logic                   res_timeout,
  output logic                   busy
);

  feeder_state_e          state_q, state_d;
  logic [BOARD_WIDTH-1:0] board_q, board_d;
  logic                   wtm_q, wtm_d;
  logic [63:0]            res_wa_q, res_wa_d;
  logic [63:0]            res_ba_q, res_ba_d;
  logic                   res_wc_q, res_wc_d;
  logic                   res_bc_q, res_bc_d;
  logic                   res_ill_q, res_ill_d;

`ifdef FEEDER_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            res_to_q, res_to_d;
  logic            expired;

  assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  // Held at zero outside WAIT, so it always starts from zero on entry.
  assign cnt_d   = (state_q == StWait) ? cnt_q + 1'b1 : '0;
  assign res_timeout = res_to_q;
  logic unused_params;
  assign unused_params = ^{32'(SIDE_WIDTH)};
`else
  assign res_timeout = 1'b0;
  logic unused_params;
  assign unused_params = ^{32'(SIDE_WIDTH), 32'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    wtm_d     = wtm_q;
    res_wa_d  = res_wa_q;
    res_ba_d  = res_ba_q;
    res_wc_d  = res_wc_q;
    res_bc_d  = res_bc_q;
    res_ill_d = res_ill_q;
`ifdef FEEDER_TIMEOUT_EN
    res_to_d  = res_to_q;
`endif
    case (state_q)
      StIdle: begin
        // Clear first so a same-cycle write still lands.
        if (clear_board) board_d = '0;
        if (wr_valid) begin
          board_d[32'(wr_square) * PIECE_WIDTH +: PIECE_WIDTH] = wr_piece;
          if (wr_last) begin
            wtm_d   = wr_white_to_move;
            state_d = StLaunch;
          end
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (is_attacking_done) begin
          res_wa_d  = white_is_attacking;
          res_ba_d  = black_is_attacking;
          res_wc_d  = white_in_check;
          res_bc_d  = black_in_check;
          res_ill_d = wtm_q ? black_in_check : white_in_check;
`ifdef FEEDER_TIMEOUT_EN
          res_to_d  = 1'b0;
`endif
          state_d   = StResult;
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (expired) begin
          res_wa_d  = '0;
          res_ba_d  = '0;
          res_wc_d  = 1'b0;
          res_bc_d  = 1'b0;
          res_ill_d = 1'b0;
          res_to_d  = 1'b1;
          state_d   = StResult;
        end
`endif
      end
      StResult: if (res_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      board_q   <= '0;
      wtm_q     <= 1'b0;
      res_wa_q  <= '0;
      res_ba_q  <= '0;
      res_wc_q  <= 1'b0;
      res_bc_q  <= 1'b0;
      res_ill_q <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      cnt_q     <= '0;
      res_to_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      wtm_q     <= wtm_d;
      res_wa_q  <= res_wa_d;
      res_ba_q  <= res_ba_d;
      res_wc_q  <= res_wc_d;
      res_bc_q  <= res_bc_d;
      res_ill_q <= res_ill_d;
`ifdef FEEDER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      res_to_q  <= res_to_d;
`endif
    end
  end

  assign board               = board_q;
  assign white_to_move       = wtm_q;
  assign board_valid         = (state_q == StLaunch);
  assign res_valid           = (state_q == StResult);
  assign wr_ready            = (state_q == StIdle);
  assign busy                = (state_q != StIdle);
  assign res_white_attacking = res_wa_q;
  assign res_black_attacking = res_ba_q;
  assign res_white_in_check  = res_wc_q;
  assign res_black_in_check  = res_bc_q;
  assign res_illegal         = res_ill_q;

endmodule

// File: tb/tb_board_feeder.sv
// Self-checking bench for board_feeder: table-driven evaluations, hand-written corner sequences
// and randomized traffic against a square-array board model.
module tb_board_feeder;

  localparam int unsigned PW = 4;
  localparam int unsigned BW = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid, wr_ready, wr_last, wr_white_to_move, clear_board;
  logic [5:0]    wr_square;
  logic [PW-1:0] wr_piece;
  logic [BW-1:0] board;
  logic          board_valid, white_to_move;
  logic          is_attacking_done, white_in_check, black_in_check;
  logic [63:0]   white_is_attacking, black_is_attacking;
  logic          res_valid, res_ready;
  logic [63:0]   res_white_attacking, res_black_attacking;
  logic          res_white_in_check, res_black_in_check, res_illegal, res_timeout, busy;

  always #5 clk = ~clk;

  board_feeder #(
    .PIECE_WIDTH(4), .SIDE_WIDTH(3), .BOARD_WIDTH(256), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_square(wr_square), .wr_piece(wr_piece),
    .wr_last(wr_last), .wr_white_to_move(wr_white_to_move), .clear_board(clear_board),
    .board(board), .board_valid(board_valid), .white_to_move(white_to_move),
    .is_attacking_done(is_attacking_done), .white_is_attacking(white_is_attacking),
    .black_is_attacking(black_is_attacking), .white_in_check(white_in_check),
    .black_in_check(black_in_check), .res_valid(res_valid), .res_ready(res_ready),
    .res_white_attacking(res_white_attacking), .res_black_attacking(res_black_attacking),
    .res_white_in_check(res_white_in_check), .res_black_in_check(res_black_in_check),
    .res_illegal(res_illegal), .res_timeout(res_timeout), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] mb [64];

  typedef struct {
    logic [5:0]    sq;
    logic [PW-1:0] pc;
    logic          wtm;
    logic          wchk;
    logic          bchk;
    int            dly;
    int            bp;
    logic          exp_ill;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [BW-1:0] model_board();
    logic [BW-1:0] r;
    for (int i = 0; i < 64; i++) r[i*PW +: PW] = mb[i];
    return r;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_op(input logic v, input logic [5:0] sq, input logic [PW-1:0] pc,
                         input logic clr);
    wr_valid = v; wr_square = sq; wr_piece = pc; clear_board = clr; wr_last = 1'b0;
    check1("wr_ready_idle", wr_ready, 1'b1);
    @(negedge clk);
    if (clr) foreach (mb[i]) mb[i] = '0;
    if (v) mb[sq] = pc;
    wr_valid = 1'b0; clear_board = 1'b0;
    checkw("board_idle", board, model_board());
  endtask

  // Final write, LAUNCH checks; returns at the first WAIT-cycle negedge.
  task automatic launch(input logic [5:0] sq, input logic [PW-1:0] pc, input logic wtm,
                        input logic early);
    wr_valid = 1'b1; wr_last = 1'b1; wr_square = sq; wr_piece = pc;
    wr_white_to_move = wtm; clear_board = 1'b0;
    check1("wr_ready_pre_launch", wr_ready, 1'b1);
    @(negedge clk);
    mb[sq] = pc;
    wr_valid = 1'b0; wr_last = 1'b0; wr_white_to_move = ~wtm;
    check1("board_valid_launch", board_valid, 1'b1);
    check1("busy_launch", busy, 1'b1);
    check1("wr_ready_launch", wr_ready, 1'b0);
    check1("wtm_latched", white_to_move, wtm);
    checkw("board_launch", board, model_board());
    if (early) begin
      is_attacking_done = 1'b1;
      white_is_attacking = 64'hdead_beef_0bad_f00d;
    end
    @(negedge clk);
    is_attacking_done = 1'b0;
    check1("board_valid_once", board_valid, 1'b0);
  endtask

  task automatic drain(input logic [63:0] wb, input logic [63:0] bb, input logic wchk,
                       input logic bchk, input logic ill, input logic to, input int bp);
    for (int i = 0; i <= bp; i++) begin
      check1("res_valid", res_valid, 1'b1);
      checkw("res_white_att", BW'(res_white_attacking), BW'(wb));
      checkw("res_black_att", BW'(res_black_attacking), BW'(bb));
      check1("res_white_chk", res_white_in_check, wchk);
      check1("res_black_chk", res_black_in_check, bchk);
      check1("res_illegal", res_illegal, ill);
      check1("res_timeout", res_timeout, to);
      check1("wr_ready_result", wr_ready, 1'b0);
      white_is_attacking = {$urandom, $urandom}; black_is_attacking = {$urandom, $urandom};
      white_in_check = 1'($urandom); black_in_check = 1'($urandom);
      is_attacking_done = 1'($urandom);
      wr_valid = 1'b1; clear_board = 1'b1;
      if (i == bp) res_ready = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0; clear_board = 1'b0; is_attacking_done = 1'b0;
    end
    res_ready = 1'b0;
    check1("res_valid_done", res_valid, 1'b0);
    check1("busy_done", busy, 1'b0);
    check1("wr_ready_done", wr_ready, 1'b1);
    checkw("board_after", board, model_board());
  endtask

  task automatic run_eval(input vec_t v, input logic early);
    logic [63:0] wb, bb;
    wb = {$urandom, $urandom};
    bb = {$urandom, $urandom};
    launch(v.sq, v.pc, v.wtm, early);
    for (int i = 0; i < v.dly; i++) begin
      wr_valid = 1'b1; wr_square = 6'($urandom); wr_piece = PW'($urandom); clear_board = 1'b1;
      check1("res_valid_wait", res_valid, 1'b0);
      check1("busy_wait", busy, 1'b1);
      @(negedge clk);
      wr_valid = 1'b0; clear_board = 1'b0;
      checkw("board_wait", board, model_board());
    end
    is_attacking_done = 1'b1; white_is_attacking = wb; black_is_attacking = bb;
    white_in_check = v.wchk; black_in_check = v.bchk;
    @(negedge clk);
    is_attacking_done = 1'b0;
    drain(wb, bb, v.wchk, v.bchk, v.exp_ill, 1'b0, v.bp);
  endtask

  // n WAIT cycles without done, except optionally in the last one.
  task automatic wait_eval(input int n, input logic done_last, input logic exp_to);
    logic [63:0] wb, bb;
    wb = {$urandom, $urandom};
    bb = {$urandom, $urandom};
    launch(6'd5, 4'h2, 1'b0, 1'b0);
    for (int k = 1; k <= n; k++) begin
      check1("res_valid_long_wait", res_valid, 1'b0);
      if (k == n && done_last) begin
        is_attacking_done = 1'b1; white_is_attacking = wb; black_is_attacking = bb;
        white_in_check = 1'b1; black_in_check = 1'b0;
      end
      @(negedge clk);
      is_attacking_done = 1'b0;
    end
    if (exp_to) drain(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    else        drain(wb, bb, 1'b1, 1'b0, 1'b1, 1'b0, 1);
  endtask

  initial begin
    vecs[0] = '{sq: 6'd60, pc: 4'h9, wtm: 1'b1, wchk: 1'b0, bchk: 1'b1, dly: 4, bp: 0, exp_ill: 1'b1};
    vecs[1] = '{sq: 6'd27, pc: 4'h3, wtm: 1'b1, wchk: 1'b1, bchk: 1'b0, dly: 0, bp: 10, exp_ill: 1'b0};
    vecs[2] = '{sq: 6'd12, pc: 4'h2, wtm: 1'b0, wchk: 1'b1, bchk: 1'b0, dly: 2, bp: 3, exp_ill: 1'b1};
    vecs[3] = '{sq: 6'd40, pc: 4'hc, wtm: 1'b0, wchk: 1'b0, bchk: 1'b1, dly: 1, bp: 0, exp_ill: 1'b0};
    vecs[4] = '{sq: 6'd63, pc: 4'h6, wtm: 1'b1, wchk: 1'b1, bchk: 1'b1, dly: 0, bp: 1, exp_ill: 1'b1};
    vecs[5] = '{sq: 6'd0,  pc: 4'h0, wtm: 1'b0, wchk: 1'b0, bchk: 1'b0, dly: 5, bp: 2, exp_ill: 1'b0};

    foreach (mb[i]) mb[i] = '0;
    reset = 1'b0; wr_valid = 1'b0; wr_square = '0; wr_piece = '0; wr_last = 1'b0;
    wr_white_to_move = 1'b0; clear_board = 1'b0; is_attacking_done = 1'b0;
    white_is_attacking = '0; black_is_attacking = '0; white_in_check = 1'b0;
    black_in_check = 1'b0; res_ready = 1'b0;
    #12;
    checkw("rst_board", board, '0);
    check1("rst_board_valid", board_valid, 1'b0);
    check1("rst_res_valid", res_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_wtm", white_to_move, 1'b0);
    check1("rst_res_illegal", res_illegal, 1'b0);
    check1("rst_res_timeout", res_timeout, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check1("wr_ready_after_rst", wr_ready, 1'b1);

    // a1 = white king, then the table (first entry drops the black king on e8).
    idle_op(1'b1, 6'd0, 4'h1, 1'b0);
    for (int i = 0; i < 6; i++) run_eval(vecs[i], 1'b0);

    // Clear with a simultaneous write keeps only the written square.
    idle_op(1'b1, 6'd27, 4'h3, 1'b1);
    checkw("clear_plus_write", board, BW'(4'h3) << (27 * 4));

    // Done during LAUNCH only must not complete the evaluation.
    run_eval('{sq: 6'd9, pc: 4'hb, wtm: 1'b1, wchk: 1'b0, bchk: 1'b1, dly: 3, bp: 0,
               exp_ill: 1'b1}, 1'b1);

    // Reset in WAIT abandons the evaluation; a late done is ignored.
    launch(6'd33, 4'h5, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    foreach (mb[i]) mb[i] = '0;
    checkw("midrst_board", board, '0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_res_valid", res_valid, 1'b0);
    check1("midrst_wtm", white_to_move, 1'b0);
    checkw("midrst_res_wa", BW'(res_white_attacking), '0);
    check1("midrst_res_illegal", res_illegal, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    is_attacking_done = 1'b1; white_is_attacking = '1; white_in_check = 1'b1;
    @(negedge clk);
    is_attacking_done = 1'b0;
    check1("late_done_res_valid", res_valid, 1'b0);
    check1("late_done_busy", busy, 1'b0);
    checkw("late_done_res_wa", BW'(res_white_attacking), '0);
    check1("late_done_wr_ready", wr_ready, 1'b1);

`ifdef FEEDER_TIMEOUT_EN
    wait_eval(8, 1'b0, 1'b1);
    wait_eval(8, 1'b1, 1'b0);
`else
    wait_eval(20, 1'b1, 1'b0);
`endif

    // Random traffic against the square-array model.
    for (int it = 0; it < 40; it++) begin
      vec_t v;
      int n_ops;
      n_ops = $urandom_range(1, 8);
      for (int j = 0; j < n_ops; j++)
        idle_op(1'($urandom), 6'($urandom), PW'($urandom), ($urandom_range(0, 15) == 0));
      v.sq = 6'($urandom); v.pc = PW'($urandom); v.wtm = 1'($urandom);
      v.wchk = 1'($urandom); v.bchk = 1'($urandom);
      v.dly = $urandom_range(0, 6); v.bp = $urandom_range(0, 3);
      v.exp_ill = v.wtm ? v.bchk : v.wchk;
      run_eval(v, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
